// File: rtl/mux_n_stream_pkg.sv
// Shared types and helpers for the N-channel stream multiplexer.
// Imported by the arbiter and the top level.
package mux_n_stream_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_stream_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr wins,
// wrapping from N-1 back to 0 without relying on a power-of-two channel count.
module rr_arbiter
    import mux_n_stream_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    int w_idx;

    // Walk offsets from farthest to nearest so the closest requester to ptr is the last write.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                gnt_idx = w_idx[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_n_stream.sv
// N-channel, W-bit stream multiplexer with a single registered output stage.
// Grants come either from a fixed select or from a round-robin arbiter.
module mux_n_stream
    import mux_n_stream_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 4,
    localparam int SW = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  mux_mode_t     mode,
    input  logic [SW-1:0] sel,
    input  logic [N-1:0]  in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]  in_ready,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_ch,
    input  logic          out_ready
);

    logic          r_outValid;
    logic [W-1:0]  r_outData;
    logic [SW-1:0] r_outCh;
    logic [SW-1:0] r_rrPtr;

    logic          w_selOk;
    logic          w_fixVld;
    logic          w_rrVld;
    logic [SW-1:0] w_rrIdx;
    logic          w_gntVld;
    logic [SW-1:0] w_gntIdx;
    logic          w_accept;
    logic          w_xfer;
    logic [W-1:0]  w_gntData;
    logic [SW-1:0] w_nextPtr;

    rr_arbiter #(.N(N)) u_arb (
        .req     (in_valid),
        .ptr     (r_rrPtr),
        .gnt_vld (w_rrVld),
        .gnt_idx (w_rrIdx)
    );

    // A select beyond the last channel (possible when N is not a power of two) grants nothing.
    assign w_selOk  = (int'(sel) < N);
    assign w_fixVld = w_selOk ? in_valid[sel] : 1'b0;

    assign w_gntVld = (mode == MODE_RR) ? w_rrVld : w_fixVld;
    assign w_gntIdx = (mode == MODE_RR) ? w_rrIdx : sel;

    assign w_accept = !r_outValid || out_ready;
    assign w_xfer   = rst_n && w_accept && w_gntVld;

    // Indexed select keeps unknowns on non-granted channels away from the output.
    assign w_gntData = in_data[w_gntIdx*W +: W];
    assign w_nextPtr = (w_gntIdx == SW'(N - 1)) ? '0 : w_gntIdx + 1'b1;

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gntIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_rrPtr    <= '0;
        end else if (w_xfer) begin
            r_outValid <= 1'b1;
            r_outData  <= w_gntData;
            r_outCh    <= w_gntIdx;
            r_rrPtr    <= w_nextPtr;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_ch    = r_outCh;

endmodule

// File: tb/tb_mux_n_stream.sv
// Scoreboard bench for mux_n_stream: a 4-channel and a 5-channel instance share clock and reset.
// Stimulus pushes expected words; negedge monitors pop and compare on each output handshake.
module tb_mux_n_stream;
    import mux_n_stream_pkg::*;

    typedef struct {
        logic [3:0] data;
        int         ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mux_mode_t   mode4 = MODE_FIXED;
    logic [1:0]  sel4 = '0;
    logic [3:0]  inValid4 = '0;
    logic [15:0] inData4 = '0;
    logic [3:0]  inReady4;
    logic        outValid4;
    logic [3:0]  outData4;
    logic [1:0]  outCh4;
    logic        outReady4 = 1'b1;

    mux_mode_t   mode5 = MODE_FIXED;
    logic [2:0]  sel5 = '0;
    logic [4:0]  inValid5 = '0;
    logic [19:0] inData5 = '0;
    logic [4:0]  inReady5;
    logic        outValid5;
    logic [3:0]  outData5;
    logic [2:0]  outCh5;
    logic        outReady5 = 1'b1;

    logic [3:0] chanVal4 [4];
    logic [3:0] chanVal5 [5];

    exp_t q4[$];
    exp_t q5[$];

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mux_n_stream #(.N(4), .W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .in_valid(inValid4), .in_data(inData4), .in_ready(inReady4),
        .out_valid(outValid4), .out_data(outData4), .out_ch(outCh4), .out_ready(outReady4)
    );

    mux_n_stream #(.N(5), .W(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_valid(inValid5), .in_data(inData5), .in_ready(inReady5),
        .out_valid(outValid5), .out_data(outData5), .out_ch(outCh5), .out_ready(outReady5)
    );

    // Single comparison point so every check steps the same counters.
    function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input mux_mode_t m, input logic [1:0] s, input logic [3:0] v);
        mode4 = m;
        sel4 = s;
        inValid4 = v;
        for (int i = 0; i < 4; i++) inData4[i*4 +: 4] = chanVal4[i];
        #1;
    endtask

    task automatic applyStimulus5(input mux_mode_t m, input logic [2:0] s, input logic [4:0] v);
        mode5 = m;
        sel5 = s;
        inValid5 = v;
        for (int i = 0; i < 5; i++) inData5[i*4 +: 4] = chanVal5[i];
        #1;
    endtask

    task automatic expect4(input int ch);
        exp_t e;
        e.data = chanVal4[ch];
        e.ch = ch;
        q4.push_back(e);
    endtask

    task automatic expect5(input int ch);
        exp_t e;
        e.data = chanVal5[ch];
        e.ch = ch;
        q5.push_back(e);
    endtask

    // Monitors: a word leaves the DUT when valid and ready are both high at the coming edge.
    always @(negedge clk) begin
        if (rst_n && outValid4 && outReady4) begin
            if (q4.size() == 0) begin
                checkOutput("dut4 unexpected word", 32'(outCh4), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q4.pop_front();
                checkOutput("dut4 out_data", 32'(outData4), 32'(e.data));
                checkOutput("dut4 out_ch", 32'(outCh4), 32'(e.ch));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && outValid5 && outReady5) begin
            if (q5.size() == 0) begin
                checkOutput("dut5 unexpected word", 32'(outCh5), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q5.pop_front();
                checkOutput("dut5 out_data", 32'(outData5), 32'(e.data));
                checkOutput("dut5 out_ch", 32'(outCh5), 32'(e.ch));
            end
        end
    end

    initial begin
        int waitCycles;
        chanVal4[0] = 4'h1; chanVal4[1] = 4'h2; chanVal4[2] = 4'h5; chanVal4[3] = 4'h9;
        chanVal5[0] = 4'h3; chanVal5[1] = 4'h6; chanVal5[2] = 4'h8; chanVal5[3] = 4'hB; chanVal5[4] = 4'hE;

        // Reset: no ready while held in reset, outputs cleared after one edge.
        rst_n = 1'b0;
        applyStimulus(MODE_FIXED, 2'd0, 4'b1111);
        applyStimulus5(MODE_FIXED, 3'd0, 5'b11111);
        checkOutput("in_ready during reset", 32'(inReady4), 32'h0);
        tick();
        checkOutput("reset out_valid", 32'(outValid4), 32'h0);
        checkOutput("reset out_data", 32'(outData4), 32'h0);
        checkOutput("reset out_ch", 32'(outCh4), 32'h0);
        applyStimulus5(MODE_FIXED, 3'd0, 5'b00000);
        rst_n = 1'b1;

        $display("[TB] fixed select sweep");
        for (int s = 0; s < 4; s++) begin
            applyStimulus(MODE_FIXED, 2'(s), 4'b1111);
            checkOutput("fixed in_ready one-hot", 32'(inReady4), 32'(1 << s));
            expect4(s);
            tick();
        end

        $display("[TB] fixed select with unknown data on ch3");
        chanVal4[0] = 4'd7; chanVal4[1] = 4'd10; chanVal4[2] = 4'd3; chanVal4[3] = 4'bxxxx;
        applyStimulus(MODE_FIXED, 2'd2, 4'b1111);
        expect4(2);
        tick();
        applyStimulus(MODE_FIXED, 2'd3, 4'b1111);
        expect4(3);
        tick();
        applyStimulus(MODE_FIXED, 2'd3, 4'b0000);
        tick();

        $display("[TB] round-robin all valid");
        chanVal4[3] = 4'hC;
        applyStimulus(MODE_RR, 2'd0, 4'b1111);
        for (int k = 0; k < 6; k++) begin
            expect4(k % 4);
            tick();
            checkOutput("rr out_valid held high", 32'(outValid4), 32'h1);
        end
        applyStimulus(MODE_RR, 2'd0, 4'b0000);
        tick();

        $display("[TB] round-robin wrap on sparse requests");
        applyStimulus(MODE_FIXED, 2'd3, 4'b1000);
        expect4(3);
        tick();
        applyStimulus(MODE_RR, 2'd0, 4'b1001);
        expect4(0); tick();
        expect4(3); tick();
        expect4(0); tick();
        expect4(3); tick();
        applyStimulus(MODE_RR, 2'd0, 4'b0000);
        tick();

        applyStimulus5(MODE_RR, 3'd0, 5'b10001);
        expect5(0); tick();
        expect5(4); tick();
        expect5(0); tick();
        applyStimulus5(MODE_RR, 3'd0, 5'b00000);
        tick();

        $display("[TB] backpressure");
        applyStimulus(MODE_RR, 2'd0, 4'b1111);
        expect4(0);
        tick();
        outReady4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("stall in_ready", 32'(inReady4), 32'h0);
            tick();
            checkOutput("stall out_valid", 32'(outValid4), 32'h1);
            checkOutput("stall out_data", 32'(outData4), 32'(chanVal4[0]));
            checkOutput("stall out_ch", 32'(outCh4), 32'h0);
        end
        outReady4 = 1'b1;
        #1;
        checkOutput("release in_ready", 32'(inReady4), 32'b0010);
        expect4(1);
        tick();
        applyStimulus(MODE_RR, 2'd0, 4'b0000);
        tick();

        $display("[TB] reset mid-stream");
        applyStimulus(MODE_RR, 2'd0, 4'b1111);
        expect4(2);
        tick();
        rst_n = 1'b0;
        void'(q4.pop_back());
        #1;
        checkOutput("reset mid in_ready", 32'(inReady4), 32'h0);
        tick();
        checkOutput("post-reset out_valid", 32'(outValid4), 32'h0);
        checkOutput("post-reset out_data", 32'(outData4), 32'h0);
        checkOutput("post-reset out_ch", 32'(outCh4), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset first rr grant", 32'(inReady4), 32'b0001);
        expect4(0);
        tick();
        applyStimulus(MODE_RR, 2'd0, 4'b0000);

        applyStimulus5(MODE_FIXED, 3'd6, 5'b11111);
        checkOutput("sel out of range in_ready", 32'(inReady5), 32'h0);
        tick();
        checkOutput("sel out of range out_valid", 32'(outValid5), 32'h0);
        applyStimulus5(MODE_FIXED, 3'd4, 5'b11111);
        checkOutput("sel 4 in_ready", 32'(inReady5), 32'b10000);
        expect5(4);
        tick();
        applyStimulus5(MODE_FIXED, 3'd0, 5'b00000);

        waitCycles = 0;
        while ((q4.size() != 0 || q5.size() != 0) && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        checkOutput("dut4 scoreboard drained", 32'(q4.size()), 32'h0);
        checkOutput("dut5 scoreboard drained", 32'(q5.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
